// File: rtl/mux4_rr_scheduler.sv
// rtl/mux4_rr_scheduler.sv - round-robin scheduler owning the select of a shared 4:1 mux with a registered output slot
module mux4_rr_scheduler #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   output logic [3:0]       ack,
   output logic [1:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_sel
);

   // The output slot is either empty or holding one word; out_valid is the state.
   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [1:0]       osel_q, osel_d;

   logic             slot_free;
   logic             grant;
   logic             found;
   logic [1:0]       win;
   logic [1:0]       idx;
   logic [WIDTH-1:0] mux_data;

   assign out_valid = (state_q == ST_FULL);
   assign out_data  = data_q;
   assign out_sel   = osel_q;

   // A word can be taken whenever the slot is empty or is being drained this cycle.
   assign slot_free = !out_valid || out_ready;
   assign grant     = slot_free && (|req) && !rst;

   // Rotating-priority search starting at the pointer; the first pending requester wins.
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      idx   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // The shared 4:1 datapath mux, steered by the winner.
   always_comb begin
      mux_data = d0;
      case (win)
         2'd0: mux_data = d0;
         2'd1: mux_data = d1;
         2'd2: mux_data = d2;
         2'd3: mux_data = d3;
         default: mux_data = d0;
      endcase
   end

   // Handshake outputs: ack only accompanies an actual capture; sel parks on out_sel otherwise.
   always_comb begin
      ack = 4'b0000;
      sel = osel_q;
      if (grant) begin
         ack = 4'b0001 << win;
         sel = win;
      end
   end

   // Next-state for the output slot and the priority pointer.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      osel_d  = osel_q;
      case (state_q)
         ST_EMPTY: begin
            if (grant) begin
               state_d = ST_FULL;
               data_d  = mux_data;
               osel_d  = win;
               ptr_d   = win + 2'd1;
            end
         end
         ST_FULL: begin
            if (grant) begin
               // Drain and refill in the same cycle: no bubble.
               state_d = ST_FULL;
               data_d  = mux_data;
               osel_d  = win;
               ptr_d   = win + 2'd1;
            end else if (out_ready) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // State registers; reset discards any pending word and restarts priority at requester 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         ptr_q   <= 2'd0;
         data_q  <= '0;
         osel_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         osel_q  <= osel_d;
      end
   end

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// tb/tb_mux4_rr_scheduler.sv - table-driven bench with output scoreboard for mux4_rr_scheduler
module tb_mux4_rr_scheduler;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] d0, d1, d2, d3;
   logic [3:0] ack;
   logic [1:0] sel;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic [1:0] out_sel;

   mux4_rr_scheduler #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .d0        (d0),
      .d1        (d1),
      .d2        (d2),
      .d3        (d3),
      .ack       (ack),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic        rdy;
      logic [15:0] d;        // {d3,d2,d1,d0}
      logic [3:0]  exp_ack;
      logic [1:0]  exp_sel;
      logic        exp_v;    // registered outputs after the edge
      logic [3:0]  exp_data;
      logic [1:0]  exp_osel;
   } vec_t;

   typedef struct {
      logic       v;
      logic [3:0] data;
      logic [1:0] osel;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[24];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_pending();
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("out_valid", {7'd0, out_valid}, {7'd0, e.v});
         chk("out_data", {4'd0, out_data}, {4'd0, e.data});
         chk("out_sel", {6'd0, out_sel}, {6'd0, e.osel});
      end
   endtask

   task automatic apply(input vec_t v);
      exp_t e;
      check_pending();
      rst       = v.rst;
      req       = v.req;
      out_ready = v.rdy;
      {d3, d2, d1, d0} = v.d;
      #1;
      chk("ack", {4'd0, ack}, {4'd0, v.exp_ack});
      chk("sel", {6'd0, sel}, {6'd0, v.exp_sel});
      e.v    = v.exp_v;
      e.data = v.exp_data;
      e.osel = v.exp_osel;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic rd,
                               input logic [15:0] dd, input logic [3:0] ea, input logic [1:0] es,
                               input logic ev, input logic [3:0] ed, input logic [1:0] eo);
      vec_t v;
      v.rst = r; v.req = rq; v.rdy = rd; v.d = dd;
      v.exp_ack = ea; v.exp_sel = es;
      v.exp_v = ev; v.exp_data = ed; v.exp_osel = eo;
      return v;
   endfunction

   initial begin
      vec_t hv;
      logic [1:0] w;

      //          rst  req     rdy d         ack     sel   v  data  osel
      // reset held with all requests pending
      vecs[0]  = mk(1, 4'b1111, 1, 16'h4321, 4'b0000, 2'd0, 0, 4'h0, 2'd0);
      vecs[1]  = mk(1, 4'b1111, 1, 16'h4321, 4'b0000, 2'd0, 0, 4'h0, 2'd0);
      // rotation 0,1,2,3,0 with no bubbles
      vecs[2]  = mk(0, 4'b1111, 1, 16'h4321, 4'b0001, 2'd0, 1, 4'h1, 2'd0);
      vecs[3]  = mk(0, 4'b1111, 1, 16'h4321, 4'b0010, 2'd1, 1, 4'h2, 2'd1);
      vecs[4]  = mk(0, 4'b1111, 1, 16'h4321, 4'b0100, 2'd2, 1, 4'h3, 2'd2);
      vecs[5]  = mk(0, 4'b1111, 1, 16'h4321, 4'b1000, 2'd3, 1, 4'h4, 2'd3);
      vecs[6]  = mk(0, 4'b1111, 1, 16'h4321, 4'b0001, 2'd0, 1, 4'h1, 2'd0);
      // single requester 2 with d2=A, then drain, then search starts at 3
      vecs[7]  = mk(0, 4'b0100, 1, 16'h4A21, 4'b0100, 2'd2, 1, 4'hA, 2'd2);
      vecs[8]  = mk(0, 4'b0000, 1, 16'h4A21, 4'b0000, 2'd2, 0, 4'hA, 2'd2);
      vecs[9]  = mk(0, 4'b1111, 1, 16'h4321, 4'b1000, 2'd3, 1, 4'h4, 2'd3);
      // fill with d1=5, stall three cycles, then release to requester 3
      vecs[10] = mk(0, 4'b0010, 1, 16'h4351, 4'b0010, 2'd1, 1, 4'h5, 2'd1);
      vecs[11] = mk(0, 4'b1001, 0, 16'h4351, 4'b0000, 2'd1, 1, 4'h5, 2'd1);
      vecs[12] = mk(0, 4'b1001, 0, 16'h4351, 4'b0000, 2'd1, 1, 4'h5, 2'd1);
      vecs[13] = mk(0, 4'b1001, 0, 16'h4351, 4'b0000, 2'd1, 1, 4'h5, 2'd1);
      vecs[14] = mk(0, 4'b1001, 1, 16'h4351, 4'b1000, 2'd3, 1, 4'h4, 2'd3);
      // bring ptr to 3, then wrap past 3 to 0 and on to 1
      vecs[15] = mk(0, 4'b0100, 1, 16'h4351, 4'b0100, 2'd2, 1, 4'h3, 2'd2);
      vecs[16] = mk(0, 4'b0011, 1, 16'h4351, 4'b0001, 2'd0, 1, 4'h1, 2'd0);
      vecs[17] = mk(0, 4'b0011, 1, 16'h4351, 4'b0010, 2'd1, 1, 4'h5, 2'd1);
      // reset while a word is stalled; restart from ptr 0
      vecs[18] = mk(0, 4'b0000, 0, 16'h4351, 4'b0000, 2'd1, 1, 4'h5, 2'd1);
      vecs[19] = mk(1, 4'b1111, 0, 16'h4351, 4'b0000, 2'd1, 0, 4'h0, 2'd0);
      vecs[20] = mk(0, 4'b0110, 1, 16'h4351, 4'b0010, 2'd1, 1, 4'h5, 2'd1);
      vecs[21] = mk(0, 4'b0110, 1, 16'h4351, 4'b0100, 2'd2, 1, 4'h3, 2'd2);
      // stall with requests pending gives no ack, then drain
      vecs[22] = mk(0, 4'b0110, 0, 16'h4351, 4'b0000, 2'd2, 1, 4'h3, 2'd2);
      vecs[23] = mk(0, 4'b0000, 1, 16'h4351, 4'b0000, 2'd2, 0, 4'h3, 2'd2);

      rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
      d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 24; i++) apply(vecs[i]);

      // Hand-written: all requesting continuously from ptr=3, grants rotate 3,0,1,2,...
      for (int k = 0; k < 8; k++) begin
         w = 2'((3 + k) % 4);
         hv = mk(0, 4'b1111, 1, 16'hDCBA, 4'b0001 << w, w, 1, 4'hA + 4'(w), w);
         apply(hv);
      end

      // Hand-written: requester 0 withdraws before being served; ptr=3 after loop, req only 1
      apply(mk(0, 4'b0010, 1, 16'hDCBA, 4'b0010, 2'd1, 1, 4'hB, 2'd1));
      apply(mk(0, 4'b0000, 1, 16'hDCBA, 4'b0000, 2'd1, 0, 4'hB, 2'd1));

      check_pending();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
